sfp_seq: RTL and testbench
==========================

SFP_SEQ -- requirements
Module: sfp_seq

Interface
REQ-001 Parameters: bw, default 4, input/SFP data width; psum_bw, default 16, psum/threshold width; cnt_bw, default 8, length-counter width.
REQ-002 clk  input  1  clock; all state changes on posedge.
REQ-003 reset  input  1  reset, synchronous, active-high; clock clk.
REQ-004 start  input  1  job request, sampled only in IDLE.
REQ-005 len  input  cnt_bw  number of input samples in the job (unsigned), latched on accepted start.
REQ-006 relu_en  input  1  apply threshold-ReLU step, latched on accepted start.
REQ-007 thres  input  psum_bw  signed threshold, latched on accepted start.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 in_valid / in_data  input  1 / bw  signed sample stream.
REQ-010 in_ready  output  1  stream ready.
REQ-011 sfp_reset, sfp_acc, sfp_relu  output  1 each  control pins of the downstream accumulate/ReLU unit.
REQ-012 sfp_in  output  bw  sample to the unit; sfp_thres  output  psum_bw  threshold to the unit.
REQ-013 sfp_out  input  psum_bw  registered psum returned by the unit.
REQ-014 res_valid / res_ready  output / input  1 / 1  result handshake; res_data  output  psum_bw  result.

Function
REQ-015 FSM states: IDLE, CLEAR, ACC, RELU, CAPTURE, RESULT.
REQ-016 IDLE: start=1 -> latch len/relu_en/thres, go CLEAR; start ignored in all other states.
REQ-017 CLEAR: sfp_reset=1 for exactly one cycle; next ACC if len!=0, else RELU if relu_en, else CAPTURE.
REQ-018 ACC: in_ready=1; a transfer is in_valid&&in_ready in the same cycle.
REQ-019 Each transfer drives sfp_acc=1 and sfp_in=in_data combinationally in that cycle, and decrements the remaining count.
REQ-020 No transfer in a cycle (in_valid=0) -> sfp_acc=0; gaps of any length are legal.
REQ-021 Transfer of the last sample (remaining count 1) -> next RELU if relu_en, else CAPTURE.
REQ-022 RELU: sfp_relu=1 for exactly one cycle, then CAPTURE.
REQ-023 CAPTURE: res_data <= sfp_out at the exiting edge; then RESULT.
REQ-024 RESULT: res_valid=1, res_data stable until res_valid&&res_ready; then IDLE.
REQ-025 sfp_thres = latched thres at all times after a start; sfp_in = 0 whenever sfp_acc=0.
REQ-026 Outside their named states, sfp_acc, sfp_relu, in_ready, res_valid are 0.
REQ-027 Latency with no input gaps and res_ready=1: res_valid rises at edge E0+N+2 (E0+N+3 with relu_en), E0 = edge sampling start, N = len.
REQ-028 No arithmetic in this block; width/sign of the result are those of sfp_out, passed unmodified.
REQ-029 len=0: no in_ready pulse, result equals the cleared unit value (0).
REQ-030 res_ready=1 while res_valid=0 has no effect; start held high through RESULT does not restart until IDLE is reached.

Reset
REQ-031 reset=1 at a posedge -> state IDLE, count 0, latched len/relu_en/thres 0, res_data 0, regardless of current state.
REQ-032 sfp_reset = reset OR (state==CLEAR), so the downstream unit is cleared whenever this block is reset.
REQ-033 While reset=1: busy, in_ready, sfp_acc, sfp_relu, res_valid all 0.
REQ-034 Reset mid-job discards the job; no res_valid is produced for it.

Verification
REQ-035 len=3, relu_en=0, samples 2,-1,5 back-to-back -> one res_valid, res_data=6, at E0+5.
REQ-036 len=2, relu_en=1, thres=0, samples -3,-4 -> sfp_relu pulses once, res_data=0.
REQ-037 len=3, relu_en=1, thres=10, samples 2,-1,5 -> res_data=0; same with thres=6 -> res_data=6 (only psum<thres clears).
REQ-038 len=0, start -> one sfp_reset cycle, no in_ready, res_data=0 at E0+2.
REQ-039 len=4, in_valid low 3 cycles between samples, res_ready low 5 cycles -> sfp_acc count exactly 4, res_valid/res_data held constant until accept, then busy=0.
REQ-040 reset asserted during ACC after 2 of 4 samples -> IDLE next cycle, sfp_reset=1 during reset, no res_valid; subsequent job len=1 sample 7 -> res_data=7.

Source files
------------

// File: rtl/sfp_seq_if.sv
// sfp_seq_if: job control, sample stream, downstream-unit pins and result handshake of sfp_seq.
interface sfp_seq_if #(
    parameter int bw = 4,
    parameter int psum_bw = 16,
    parameter int cnt_bw = 8
);
    logic start;
    logic [cnt_bw-1:0] len;
    logic relu_en;
    logic [psum_bw-1:0] thres;
    logic busy;
    logic in_valid;
    logic [bw-1:0] in_data;
    logic in_ready;
    logic sfp_reset;
    logic sfp_acc;
    logic sfp_relu;
    logic [bw-1:0] sfp_in;
    logic [psum_bw-1:0] sfp_thres;
    logic [psum_bw-1:0] sfp_out;
    logic res_valid;
    logic res_ready;
    logic [psum_bw-1:0] res_data;

    modport master (
        output start, len, relu_en, thres, in_valid, in_data, sfp_out, res_ready,
        input busy, in_ready, sfp_reset, sfp_acc, sfp_relu, sfp_in, sfp_thres, res_valid, res_data
    );

    modport slave (
        input start, len, relu_en, thres, in_valid, in_data, sfp_out, res_ready,
        output busy, in_ready, sfp_reset, sfp_acc, sfp_relu, sfp_in, sfp_thres, res_valid, res_data
    );
endinterface

// File: rtl/sfp_seq.sv
// sfp_seq: sequences one clear/accumulate/ReLU/capture job on a downstream psum unit and returns its result.
module sfp_seq #(
    parameter int bw = 4,
    parameter int psum_bw = 16,
    parameter int cnt_bw = 8
) (
    input logic clk,
    input logic reset,
    sfp_seq_if.slave bus
);
    typedef enum logic [2:0] {IDLE, CLEAR, ACC, RELU, CAPTURE, RESULT} state_t;

    state_t state, next;
    logic [cnt_bw-1:0] cnt;
    logic relu_q;
    logic [psum_bw-1:0] thres_q;
    logic [psum_bw-1:0] res_q;
    logic run, acc;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            IDLE:    next = bus.start ? CLEAR : IDLE;
            CLEAR:   next = cnt != '0 ? ACC : relu_q ? RELU : CAPTURE;
            ACC:     next = (bus.in_valid && cnt == cnt_bw'(1)) ? (relu_q ? RELU : CAPTURE) : ACC;
            RELU:    next = CAPTURE;
            CAPTURE: next = RESULT;
            RESULT:  next = bus.res_ready ? IDLE : RESULT;
            default: next = IDLE;
        endcase
    end

    // Every control output is forced quiet while reset is high, except sfp_reset which clears the unit.
    always_comb begin
        run = !reset;
        bus.busy = run && state != IDLE;
        bus.in_ready = run && state == ACC;
        acc = bus.in_ready && bus.in_valid;
        bus.sfp_acc = acc;
        bus.sfp_relu = run && state == RELU;
        bus.sfp_reset = reset || state == CLEAR;
        bus.res_valid = run && state == RESULT;
        bus.sfp_in = acc ? bus.in_data : {bw{1'b0}};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
            relu_q <= 1'b0;
            thres_q <= '0;
            res_q <= '0;
        end else begin
            if (state == IDLE && bus.start) begin
                cnt <= bus.len;
                relu_q <= bus.relu_en;
                thres_q <= bus.thres;
            end else if (acc) begin
                cnt <= cnt - cnt_bw'(1);
            end
            if (state == CAPTURE) res_q <= bus.sfp_out;
        end
    end

    assign bus.sfp_thres = thres_q;
    assign bus.res_data = res_q;
endmodule

// File: tb/tb_sfp_seq.sv
// tb_sfp_seq: directed jobs against sfp_seq with a behavioural accumulate/ReLU unit on its control pins.
module tb_sfp_seq;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int total = 0;
    int passed = 0;

    sfp_seq_if b ();
    sfp_seq dut (.clk(clk), .reset(reset), .bus(b));

    always #5 clk = ~clk;

    // Downstream unit: clear, accumulate sign-extended samples, threshold-ReLU (psum < thres -> 0).
    logic signed [15:0] psum;
    always_ff @(posedge clk) begin
        if (b.sfp_reset) psum <= '0;
        else if (b.sfp_acc) psum <= psum + {{12{b.sfp_in[3]}}, b.sfp_in};
        else if (b.sfp_relu && psum < $signed(b.sfp_thres)) psum <= '0;
    end
    assign b.sfp_out = psum;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic run_job(input int n, input bit r, input int th, input int s0, input int s1,
                           input int s2, input int s3, input int gap, input int hold,
                           output int lat, output int res, output int accs, output int relus,
                           output int clears, output int readys, output bit stable);
        int smp[4];
        int idx, g, k, vc;
        bit done;
        smp = '{s0, s1, s2, s3};
        lat = -1; res = 0; accs = 0; relus = 0; clears = 0; readys = 0; stable = 1'b1;
        idx = 0; g = 0; k = 0; vc = 0; done = 1'b0;
        b.start = 1'b1; b.len = 8'(n); b.relu_en = r; b.thres = 16'(th);
        @(negedge clk);
        b.start = 1'b0;
        while (!done && k < 200) begin
            b.in_valid = 1'b0;
            b.res_ready = 1'b0;
            if (b.in_ready && idx < n) begin
                if (g == 0) begin
                    b.in_valid = 1'b1;
                    b.in_data = smp[idx][3:0];
                end else g--;
            end
            if (b.res_valid) begin
                vc++;
                if (lat < 0) begin
                    lat = k;
                    res = int'($signed(b.res_data));
                end else if (int'($signed(b.res_data)) != res) stable = 1'b0;
                b.res_ready = vc > hold;
            end
            #1;
            accs += int'(b.sfp_acc);
            relus += int'(b.sfp_relu);
            clears += int'(b.sfp_reset);
            readys += int'(b.in_ready);
            if (b.sfp_acc) begin
                idx++;
                g = gap;
            end
            done = b.res_valid && b.res_ready;
            @(negedge clk);
            k++;
        end
        b.in_valid = 1'b0;
        b.res_ready = 1'b0;
    endtask

    int lat, res, accs, relus, clears, readys, rv;
    bit stable;

    initial begin
        b.start = 1'b0; b.len = '0; b.relu_en = 1'b0; b.thres = '0;
        b.in_valid = 1'b0; b.in_data = '0; b.res_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", int'(b.busy), 0);
        check("rst_sfp_reset", int'(b.sfp_reset), 1);
        check("rst_res_valid", int'(b.res_valid), 0);
        check("rst_in_ready", int'(b.in_ready), 0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_busy", int'(b.busy), 0);
        check("idle_res_data", int'(b.res_data), 0);
        check("idle_thres", int'(b.sfp_thres), 0);

        run_job(3, 0, 0, 2, -1, 5, 0, 0, 0, lat, res, accs, relus, clears, readys, stable);
        check("sum_lat", lat, 5);
        check("sum_res", res, 6);
        check("sum_accs", accs, 3);
        check("sum_relus", relus, 0);
        check("sum_clears", clears, 1);
        check("sum_idle", int'(b.busy), 0);

        run_job(2, 1, 0, -3, -4, 0, 0, 0, 0, lat, res, accs, relus, clears, readys, stable);
        check("neg_lat", lat, 5);
        check("neg_res", res, 0);
        check("neg_relus", relus, 1);

        run_job(3, 1, 10, 2, -1, 5, 0, 0, 0, lat, res, accs, relus, clears, readys, stable);
        check("th10_lat", lat, 6);
        check("th10_res", res, 0);
        check("th10_thres", int'(b.sfp_thres), 10);

        run_job(3, 1, 6, 2, -1, 5, 0, 0, 0, lat, res, accs, relus, clears, readys, stable);
        check("th6_res", res, 6);
        check("th6_thres", int'(b.sfp_thres), 6);

        run_job(0, 0, 0, 0, 0, 0, 0, 0, 0, lat, res, accs, relus, clears, readys, stable);
        check("len0_lat", lat, 2);
        check("len0_res", res, 0);
        check("len0_clears", clears, 1);
        check("len0_readys", readys, 0);

        run_job(4, 0, 0, 1, 2, 3, -4, 3, 5, lat, res, accs, relus, clears, readys, stable);
        check("gap_accs", accs, 4);
        check("gap_res", res, 2);
        check("gap_stable", int'(stable), 1);
        check("gap_idle", int'(b.busy), 0);

        b.start = 1'b1; b.len = 8'd4; b.relu_en = 1'b0; b.thres = '0;
        @(negedge clk);
        b.start = 1'b0;
        @(negedge clk);
        b.in_valid = 1'b1; b.in_data = 4'd1;
        repeat (2) @(negedge clk);
        b.in_valid = 1'b0;
        reset = 1'b1;
        #1;
        check("mid_rst_sfp_reset", int'(b.sfp_reset), 1);
        check("mid_rst_busy", int'(b.busy), 0);
        check("mid_rst_in_ready", int'(b.in_ready), 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("post_rst_busy", int'(b.busy), 0);
        rv = 0;
        b.res_ready = 1'b1;
        repeat (10) begin
            @(negedge clk);
            rv += int'(b.res_valid);
        end
        b.res_ready = 1'b0;
        check("post_rst_no_result", rv, 0);

        run_job(1, 0, 0, 7, 0, 0, 0, 0, 0, lat, res, accs, relus, clears, readys, stable);
        check("after_rst_lat", lat, 3);
        check("after_rst_res", res, 7);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
